// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Number of entries addressed by an addr_w-bit index.
  function automatic int unsigned depth_f(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// Read-select mux for one read port: zero register, write bypass, array data.
// The output register lives in the top level.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b0
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] data_o
);

  // Zero register wins over bypass; otherwise forward same-cycle write data.
  always_comb begin
    data_o = mem_data_i;
    if (ZERO_REG && (addr_i == '0)) begin
      data_o = '0;
    end else if (BYPASS && we_i && (wr_i == addr_i)) begin
      data_o = wd_i;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two registered read ports,
// optional zero register and bypass, and a sequential clear engine.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        ADDR_W   = 5,
  parameter bit                 ZERO_REG = 1'b1,
  parameter bit                 BYPASS   = 1'b0,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] wr,
  input  logic [DATA_W-1:0] wd,
  input  logic              we,
  input  logic              clr_req,
  output logic [DATA_W-1:0] rda,
  output logic [DATA_W-1:0] rdb,
  output logic              busy
);

  // state | meaning
  // IDLE  | normal operation: writes accepted, reads registered
  // CLEAR | engine writes INIT_VAL to mem[cnt]; writes ignored, reads 0

  localparam int unsigned       DEPTH    = depth_f(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rda_q, rda_d;
  logic [DATA_W-1:0] rdb_q, rdb_d;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  regfile_rd_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rd_a (
    .addr_i    (ra),
    .we_i      (we),
    .wr_i      (wr),
    .wd_i      (wd),
    .mem_data_i(mem[ra]),
    .data_o    (sel_a)
  );

  regfile_rd_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rd_b (
    .addr_i    (rb),
    .we_i      (we),
    .wr_i      (wr),
    .wd_i      (wd),
    .mem_data_i(mem[rb]),
    .data_o    (sel_b)
  );

  // Next-state, read data and the single array write request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rda_d     = '0;
    rdb_d     = '0;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = INIT_VAL;
    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        rda_d = sel_a;
        rdb_d = sel_b;
        if (we && !(ZERO_REG && (wr == '0))) begin
          mem_we    = 1'b1;
          mem_waddr = wr;
          mem_wdata = wd;
        end
        // Same-cycle write above still lands; the clear overwrites it later.
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and output registers; reset restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rda_q   <= '0;
      rdb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rda_q   <= rda_d;
      rdb_q   <= rdb_d;
    end
  end

  // Array storage is not reset; the clear engine initialises it.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rda  = rda_q;
  assign rdb  = rdb_q;
  assign busy = (state_q == CLEAR);

endmodule
